mux_arbiter: RTL and testbench
==============================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset (clk, reset), and all state SHALL change only on the rising edge of clk.
REQ-002 Parameter: MAXBURST, default 4, maximum consecutive grant cycles per requester; legal range 1..8.
REQ-003 Port: clk  input  1  system clock.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: req  input  8  request lines; bit i = requester i.
REQ-006 Port: d  input  8  data lines; bit i = requester i data (shared 8:1 mux inputs).
REQ-007 Port: gnt  output  8  registered one-hot grant; all zero when idle.
REQ-008 Port: sel  output  3  registered mux select = index of granted requester.
REQ-009 Port: valid  output  1  registered; 1 while a grant is active.
REQ-010 Port: y  output  1  combinational: d[sel] when valid=1, else 0.

Function
REQ-011 The FSM SHALL have two states, IDLE and BUSY; valid=1 exactly in BUSY.
REQ-012 Internal state SHALL comprise: 3-bit round-robin pointer ptr, 3-bit burst counter cnt, state, sel.
REQ-013 Arbitration order SHALL be circular: ptr, ptr+1, ..., ptr+7, all mod 8 (7 wraps to 0); the first index with req=1 wins.
REQ-014 IDLE, req=0: stay IDLE; gnt=0, sel holds, cnt=0.
REQ-015 IDLE, any req=1 at edge k: enter BUSY at edge k; gnt/sel/valid visible in the cycle after edge k (latency one cycle), cnt=0.
REQ-016 BUSY: gnt[sel]=1 and all other bits 0; y tracks d[sel] combinationally with no added latency.
REQ-017 BUSY, no release: cnt increments by 1 each edge.
REQ-018 Release SHALL occur at an edge where req[sel]=0 or cnt=MAXBURST-1.
REQ-019 On release, ptr SHALL load sel+1 mod 8.
REQ-020 On release, the new grant SHALL be arbitrated in the same edge, starting from sel+1 mod 8; the releasing requester is eligible only last.
REQ-021 Release with a winner: stay BUSY with new sel/gnt and cnt=0; no idle bubble.
REQ-022 Release with no winner: go to IDLE; gnt=0, valid=0.
REQ-023 A requester whose req drops SHALL lose its grant at the next edge, i.e. at most one cycle after deassertion.
REQ-024 With MAXBURST=1, grants SHALL rotate every cycle among active requesters.
REQ-025 Changes to req bits other than req[sel] during BUSY SHALL NOT affect the current grant.
REQ-026 With a single continuous requester i, it SHALL be regranted after each burst with cnt cleared and no gap cycle.

Reset
REQ-027 At any edge with reset=1: state=IDLE, ptr=0, cnt=0, sel=0, gnt=0, valid=0; hence y=0. Reset SHALL override all other inputs.
REQ-028 Reset asserted mid-burst SHALL drop the grant at that edge; the first grant after reset SHALL be arbitrated from index 0.

Verification
REQ-029 Reset, then req=8'h00 for 5 cycles -> gnt=0, valid=0, y=0, sel=0 throughout.
REQ-030 req=8'h24 (bits 2,5) from reset, held, MAXBURST=4 -> gnt=8'h04 for 4 cycles, then 8'h20 for 4 cycles, then 8'h04 again; no valid gap.
REQ-031 req=8'h80 only; drop req[7] after 2 granted cycles -> gnt=8'h80 for 2 cycles, then gnt=0, valid=0 at the next edge; a later grant searches from index 0 (ptr wrapped 7->0).
REQ-032 req=8'hFF, MAXBURST=1 -> sel sequence 0,1,2,...,7,0 on consecutive cycles; gnt always one-hot.
REQ-033 Granted to 3 with d=8'h08, then d=8'h00 -> y=1, then 0 in the same cycle as the d change; valid=1.
REQ-034 Reset pulsed during the 2nd cycle of a burst to requester 4 with req=8'h11 -> valid=0 the cycle after reset; after release, gnt=8'h01 first (ptr=0).

Source files
------------

// File: rtl/mux_arbiter.sv
// Round-robin 8:1 arbiter with a burst limit and a shared data mux.
// A grant lasts until the owner drops its request or MAXBURST cycles have
// elapsed. The next grant is arbitrated in the same edge, so a busy arbiter
// never shows an idle bubble between owners.
module mux_arbiter #(
  parameter int unsigned MAXBURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       y
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Counter value during the final cycle of a full-length burst.
  localparam logic [2:0] LastCnt = 3'(MAXBURST - 1);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       release_grant;
  logic [2:0] next_start;

  // Circular priority search. Offsets are scanned from the far end toward
  // the start, so the last hit is the one closest to the start index.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    rr_pick = start;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign release_grant = !req[sel_q] || (cnt_q == LastCnt);
  assign next_start    = sel_q + 3'd1;

  // Next-state: arbitrate from ptr when idle, from sel+1 on release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (|req) begin
          state_d = StBusy;
          sel_d   = rr_pick(req, ptr_q);
        end
      end
      StBusy: begin
        if (release_grant) begin
          ptr_d = next_start;
          cnt_d = 3'd0;
          if (|req) begin
            sel_d = rr_pick(req, next_start);
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    gnt_d = (state_d == StBusy) ? (8'd1 << sel_d) : 8'd0;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 3'd0;
      cnt_q   <= 3'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs: registered grant/select/valid, combinational data mux.
  always_comb begin
    gnt   = gnt_q;
    sel   = sel_q;
    valid = (state_q == StBusy);
    y     = valid & d[sel_q];
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench: two arbiters (MAXBURST=4 and MAXBURST=1) share the
// same stimulus and are compared each cycle against a behavioural model.
module tb_mux_arbiter;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] d;
  logic [7:0] gnt4, gnt1;
  logic [2:0] sel4, sel1;
  logic       valid4, valid1;
  logic       y4, y1;

  int checks = 0;
  int errors = 0;

  // Model state per instance: index 0 -> MAXBURST=4, index 1 -> MAXBURST=1.
  int m_busy[2];
  int m_sel[2];
  int m_ptr[2];
  int m_cnt[2];
  int m_max[2] = '{4, 1};

  mux_arbiter #(.MAXBURST(4)) dut4 (
    .clk(clk), .reset(reset), .req(req), .d(d),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .y(y4)
  );

  mux_arbiter #(.MAXBURST(1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .d(d),
    .gnt(gnt1), .sel(sel1), .valid(valid1), .y(y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // First requester at or after start, walking circularly; -1 if none.
  function automatic int first_req(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_sel[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_edge(input logic rs, input logic [7:0] rq);
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        m_busy[i] = 0; m_sel[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0;
      end else if (m_busy[i] == 0) begin
        m_cnt[i] = 0;
        if (rq != 8'd0) begin
          m_busy[i] = 1;
          m_sel[i]  = first_req(rq, m_ptr[i]);
        end
      end else if (!rq[m_sel[i]] || m_cnt[i] == m_max[i] - 1) begin
        m_ptr[i] = (m_sel[i] + 1) % 8;
        m_cnt[i] = 0;
        if (rq != 8'd0) m_sel[i] = first_req(rq, m_ptr[i]);
        else            m_busy[i] = 0;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endtask

  function automatic logic [7:0] exp_gnt(input int i);
    return (m_busy[i] != 0) ? (8'd1 << m_sel[i]) : 8'd0;
  endfunction

  function automatic logic [7:0] exp_y(input int i);
    return (m_busy[i] != 0) ? 8'(d[m_sel[i]]) : 8'd0;
  endfunction

  task automatic check_y(input string tag);
    chk({tag, " y4"}, 8'(y4), exp_y(0));
    chk({tag, " y1"}, 8'(y1), exp_y(1));
  endtask

  task automatic check_all(input string tag);
    chk({tag, " gnt4"}, gnt4, exp_gnt(0));
    chk({tag, " sel4"}, 8'(sel4), 8'(m_sel[0]));
    chk({tag, " valid4"}, 8'(valid4), 8'(m_busy[0]));
    chk({tag, " gnt1"}, gnt1, exp_gnt(1));
    chk({tag, " sel1"}, 8'(sel1), 8'(m_sel[1]));
    chk({tag, " valid1"}, 8'(valid1), 8'(m_busy[1]));
    check_y(tag);
  endtask

  // One clock: drive inputs, check y before the edge, then everything after.
  task automatic cycle(input string tag, input logic rs, input logic [7:0] rq,
                       input logic [7:0] dd);
    reset = rs;
    req   = rq;
    d     = dd;
    #1;
    check_y({tag, " pre"});
    @(posedge clk);
    model_edge(rs, rq);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] exp30 [9] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h20, 8'h20, 8'h20, 8'h20, 8'h04};
    logic [7:0] rq;

    // Bring both DUTs out of the unknown power-up state.
    reset = 1'b1;
    req   = 8'h00;
    d     = 8'h00;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    check_all("reset");
    chk("reset gnt4 zero", gnt4, 8'h00);

    // Idle with no requests.
    for (int k = 0; k < 5; k++) begin
      cycle("idle", 1'b0, 8'h00, 8'($urandom));
      chk("idle valid4", 8'(valid4), 8'h00);
      chk("idle sel4", 8'(sel4), 8'h00);
      chk("idle y4", 8'(y4), 8'h00);
    end

    // Two requesters, burst of 4 each, no gap.
    cycle("rst030", 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 9; k++) begin
      cycle("burst", 1'b0, 8'h24, 8'($urandom));
      chk("burst gnt4 seq", gnt4, exp30[k]);
      chk("burst valid4", 8'(valid4), 8'h01);
    end

    // Requester 7 drops after two cycles; pointer wraps to 0.
    cycle("rst031", 1'b1, 8'h00, 8'h00);
    cycle("r7a", 1'b0, 8'h80, 8'hff);
    chk("r7 gnt4 c1", gnt4, 8'h80);
    cycle("r7b", 1'b0, 8'h80, 8'hff);
    chk("r7 gnt4 c2", gnt4, 8'h80);
    cycle("r7drop", 1'b0, 8'h00, 8'hff);
    chk("r7 drop gnt4", gnt4, 8'h00);
    chk("r7 drop valid4", 8'(valid4), 8'h00);
    cycle("r7wrap", 1'b0, 8'h81, 8'hff);
    chk("wrap gnt4", gnt4, 8'h01);

    // MAXBURST=1 rotates every cycle.
    cycle("rst032", 1'b1, 8'h00, 8'h00);
    for (int k = 0; k < 9; k++) begin
      cycle("rotate", 1'b0, 8'hff, 8'($urandom));
      chk("rotate sel1", 8'(sel1), 8'(k % 8));
      chk("rotate gnt1", gnt1, 8'd1 << (k % 8));
    end

    // y follows d[sel] within the same cycle.
    cycle("rst033", 1'b1, 8'h00, 8'h00);
    cycle("g3", 1'b0, 8'h08, 8'h08);
    chk("g3 y4 high", 8'(y4), 8'h01);
    d = 8'h00;
    #1;
    chk("g3 y4 low", 8'(y4), 8'h00);
    chk("g3 valid4", 8'(valid4), 8'h01);
    check_y("g3 dchange");

    // Reset during a burst to requester 4.
    cycle("rst034", 1'b1, 8'h00, 8'h00);
    cycle("g4a", 1'b0, 8'h10, 8'h00);
    chk("g4 gnt4", gnt4, 8'h10);
    cycle("g4b", 1'b0, 8'h11, 8'h00);
    cycle("g4rst", 1'b1, 8'h11, 8'h00);
    chk("g4 rst valid4", 8'(valid4), 8'h00);
    cycle("g4after", 1'b0, 8'h11, 8'h00);
    chk("g4 after gnt4", gnt4, 8'h01);

    // Randomized traffic, including occasional mid-run resets.
    rq = 8'h00;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 5))
        0, 1:    ;
        2:       rq = 8'd1 << $urandom_range(0, 7);
        3:       rq = (8'd1 << $urandom_range(0, 7)) | (8'd1 << $urandom_range(0, 7));
        4:       rq = 8'($urandom);
        default: rq = 8'h00;
      endcase
      cycle("rand", ($urandom_range(0, 49) == 0), rq, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
